cls_spi_rx: RTL and testbench
=============================

# cls_spi_rx

SPI-slave receiver and terminal-command decoder for the debug character display link: the counterpart of the debug console SPI transmitter. Samples `ss`/`sclk`/`mosi` in the system clock domain, assembles MSB-first bytes, and decodes the ANSI-style stream (`ESC [ p0 ; p1 final` plus printable ASCII) into writes to a 2x16 character buffer and display configuration registers. Used as a loopback checker for the debug link and as a display model in simulation.

## Interface
Parameters: none; geometry fixed at 2 rows x 16 columns.

Ports:
- `clock`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `ss`  in  1  slave select, active low
- `sclk`  in  1  serial clock, idles high; data sampled on rising edge; frequency at most `clock`/4
- `mosi`  in  1  serial data, MSB first
- `miso`  out  1  constant 0
- `rx_valid`  out  1  one-cycle strobe: `rx_byte` is a complete byte
- `rx_byte`  out  8  last received byte
- `char_we`  out  1  one-cycle character-buffer write strobe
- `char_addr`  out  5  `{row, col[3:0]}`
- `char_data`  out  8  character to write
- `cursor_row`  out  1  current row
- `cursor_col`  out  4  current column
- `disp_cfg`  out  8  last `p0` of `e`
- `cursor_cfg`  out  8  last `p0` of `c`
- `mode_cfg`  out  8  last `p0` of `h`
- `clear_busy`  out  1  high while a clear sweep runs
- `seq_err`  out  1  one-cycle strobe: malformed escape sequence
- `overrun`  out  1  one-cycle strobe: byte dropped

## Operation
- Reset (`reset`=0, asynchronous): every output 0; parser in IDLE; bit counter 0; pending register empty.
- Front end:
  - `ss`, `sclk`, `mosi` pass through 2-FF synchronizers.
  - A rising edge of synchronized `sclk` while synchronized `ss`=0 shifts in `mosi` and increments a 3-bit counter.
  - On the 8th bit: `rx_byte` loads and `rx_valid` pulses.
  - `ss` high clears the counter and discards any partial byte without a strobe.
- Pending register: one byte deep. It is loaded on `rx_valid`, and the parser consumes it one cycle later if the parser is not in CLEAR. If `rx_valid` occurs while the register is full, pulse `overrun` and drop the new byte.
- Parser states: IDLE, ESC, CSI, CLEAR.
  - IDLE
    - 0x1B → ESC.
    - 0x20–0x7E → write: `char_we`=1, `char_addr`={row,col}, `char_data`=byte. Then col+1; col 15 wraps to 0 and toggles row (row 1 wraps to 0).
    - Any other byte is ignored.
  - ESC
    - 0x5B → CSI; clear p0, p1 and the param index.
    - Else pulse `seq_err` and go to IDLE; the byte is not written.
  - CSI
    - Digit: p[idx] = p[idx]*10 + d, saturating at 255.
    - `;`: idx 0 → 1; a second `;` pulses `seq_err` and goes to IDLE.
    - Final bytes, then IDLE unless noted:
      - `H`: row=min(p0,1), col=min(p1,15).
      - `j`: if p0=0, go to CLEAR; otherwise no action.
      - `e`: `disp_cfg`=p0.
      - `c`: `cursor_cfg`=p0.
      - `h`: `mode_cfg`=p0.
      - Any other byte: `seq_err`, IDLE.
  - CLEAR
    - `clear_busy`=1.
    - 32 consecutive cycles of `char_we`=1, `char_data`=0x20, `char_addr` 0..31.
    - Then row=col=0 and go to IDLE.
    - Bytes arriving meanwhile wait in the pending register.

## Timing
- Synchronizer latency: `rx_valid` asserts exactly 3 clock cycles after the first clock edge that samples pin `sclk`=1 for bit 8.
- Printable byte: `char_we` is asserted the cycle after the pending register loads, so there are 2 cycles from `rx_valid` to `char_we`.
- Config registers and cursor update on the same edge as that consume cycle.
- CLEAR lasts exactly 32 cycles; `clear_busy` drops on the cycle after address 31 is written. A pending byte is consumed on that cycle.
- `seq_err` and `overrun` can assert on the same cycle; each is independent.
- Reset asserted mid-byte or mid-CLEAR aborts immediately; the sweep does not resume.

## Test plan
- Send bytes 1B 5B 33 65 (`ESC [ 3 e`) with `sclk`=`clock`/4 → `disp_cfg`=3; no `char_we`; no `seq_err`.
- Send `ESC [ 1 ; 5 H` then 0x41 → `char_we` with `char_addr`=0x15 and `char_data`=0x41; afterwards `cursor_col`=6.
- From row 1, col 15, send 0x42 → write at address 0x1F, then cursor=(0,0).
- Send `ESC [ 0 j` then 0x43 immediately → 32 writes of 0x20 at addresses 0..31, then 0x43 written at address 0x00. No `overrun`.
- Send `ESC [ 9 9 9 ; 4 0 H` → row=1, col=15 (saturation and clamp). Then `ESC X` → `seq_err` pulse and no write.
- Raise `ss` after 5 bits, then send 0x44 → no `rx_valid` for the partial byte; the next full byte is 0x44. Assert `reset` mid-CLEAR → `clear_busy`=0 and all outputs 0.

Source files
------------

// File: rtl/cls_spi_rx.sv
// SPI-slave receiver with an ANSI-style terminal decoder driving a 2x16 character
// buffer, cursor and display configuration registers.
module cls_spi_rx (
  input  logic       clock,
  input  logic       reset,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       char_we,
  output logic [4:0] char_addr,
  output logic [7:0] char_data,
  output logic       cursor_row,
  output logic [3:0] cursor_col,
  output logic [7:0] disp_cfg,
  output logic [7:0] cursor_cfg,
  output logic [7:0] mode_cfg,
  output logic       clear_busy,
  output logic       seq_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, ESC, CSI, CLEAR} state_t;

  // Front end: synchronizers, then one alignment stage so the edge strobe and data line up
  logic       ss_meta_reg, ss_sync_reg, sclk_meta_reg, sclk_sync_reg, mosi_meta_reg, mosi_sync_reg;
  logic       sclk_prev_reg, rise_reg, mosi_d_reg, ss_d_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] shift_reg;
  logic       rx_valid_reg;
  logic [7:0] rx_byte_reg;

  logic       pend_full_reg, overrun_reg, consume;
  logic [7:0] pend_byte_reg;

  state_t     state_reg, state_next;
  logic [7:0] p0_reg, p0_next, p1_reg, p1_next;
  logic       idx_reg, idx_next;
  logic       row_reg, row_next;
  logic [3:0] col_reg, col_next;
  logic [4:0] clr_cnt_reg, clr_cnt_next;
  logic [7:0] disp_reg, disp_next, curcfg_reg, curcfg_next, mode_reg, mode_next;
  logic       char_we_reg, char_we_next, seq_err_reg, seq_err_next;
  logic [4:0] char_addr_reg, char_addr_next;
  logic [7:0] char_data_reg, char_data_next;
  logic [11:0] acc;
  logic [7:0] digit_sat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // ss and sclk idle high; resetting their synchronizers to 1 avoids a false edge
      ss_meta_reg   <= 1'b1;
      ss_sync_reg   <= 1'b1;
      sclk_meta_reg <= 1'b1;
      sclk_sync_reg <= 1'b1;
      mosi_meta_reg <= 1'b0;
      mosi_sync_reg <= 1'b0;
      sclk_prev_reg <= 1'b1;
      rise_reg      <= 1'b0;
      mosi_d_reg    <= 1'b0;
      ss_d_reg      <= 1'b1;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 7'd0;
      rx_valid_reg  <= 1'b0;
      rx_byte_reg   <= 8'd0;
    end else begin
      ss_meta_reg   <= ss;
      ss_sync_reg   <= ss_meta_reg;
      sclk_meta_reg <= sclk;
      sclk_sync_reg <= sclk_meta_reg;
      mosi_meta_reg <= mosi;
      mosi_sync_reg <= mosi_meta_reg;
      sclk_prev_reg <= sclk_sync_reg;
      rise_reg      <= sclk_sync_reg & ~sclk_prev_reg & ~ss_sync_reg;
      mosi_d_reg    <= mosi_sync_reg;
      ss_d_reg      <= ss_sync_reg;
      rx_valid_reg  <= 1'b0;
      if (ss_d_reg) begin
        bit_cnt_reg <= 3'd0;
      end else if (rise_reg) begin
        shift_reg   <= {shift_reg[5:0], mosi_d_reg};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          rx_byte_reg  <= {shift_reg, mosi_d_reg};
          rx_valid_reg <= 1'b1;
        end
      end
    end
  end

  // A byte being consumed this cycle frees the slot for a byte arriving now
  assign consume = pend_full_reg && (state_reg != CLEAR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_full_reg <= 1'b0;
      pend_byte_reg <= 8'd0;
      overrun_reg   <= 1'b0;
    end else begin
      overrun_reg <= rx_valid_reg && pend_full_reg && !consume;
      if (rx_valid_reg && !(pend_full_reg && !consume)) begin
        pend_full_reg <= 1'b1;
        pend_byte_reg <= rx_byte_reg;
      end else if (consume) begin
        pend_full_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      p0_reg        <= 8'd0;
      p1_reg        <= 8'd0;
      idx_reg       <= 1'b0;
      row_reg       <= 1'b0;
      col_reg       <= 4'd0;
      clr_cnt_reg   <= 5'd0;
      disp_reg      <= 8'd0;
      curcfg_reg    <= 8'd0;
      mode_reg      <= 8'd0;
      char_we_reg   <= 1'b0;
      char_addr_reg <= 5'd0;
      char_data_reg <= 8'd0;
      seq_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      p0_reg        <= p0_next;
      p1_reg        <= p1_next;
      idx_reg       <= idx_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      clr_cnt_reg   <= clr_cnt_next;
      disp_reg      <= disp_next;
      curcfg_reg    <= curcfg_next;
      mode_reg      <= mode_next;
      char_we_reg   <= char_we_next;
      char_addr_reg <= char_addr_next;
      char_data_reg <= char_data_next;
      seq_err_reg   <= seq_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    p0_next        = p0_reg;
    p1_next        = p1_reg;
    idx_next       = idx_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    clr_cnt_next   = clr_cnt_reg;
    disp_next      = disp_reg;
    curcfg_next    = curcfg_reg;
    mode_next      = mode_reg;
    char_we_next   = 1'b0;
    char_addr_next = char_addr_reg;
    char_data_next = char_data_reg;
    seq_err_next   = 1'b0;
    // Decimal accumulate with saturation; 12 bits hold 255*10+9
    acc       = 12'(idx_reg ? p1_reg : p0_reg) * 12'd10 + {8'd0, pend_byte_reg[3:0]};
    digit_sat = (acc > 12'd255) ? 8'hFF : acc[7:0];
    case (state_reg)
      IDLE: if (consume) begin
        if (pend_byte_reg == 8'h1B) begin
          state_next = ESC;
        end else if (pend_byte_reg >= 8'h20 && pend_byte_reg <= 8'h7E) begin
          char_we_next   = 1'b1;
          char_addr_next = {row_reg, col_reg};
          char_data_next = pend_byte_reg;
          col_next       = col_reg + 4'd1;
          if (col_reg == 4'd15) row_next = ~row_reg;
        end
      end
      ESC: if (consume) begin
        if (pend_byte_reg == 8'h5B) begin
          state_next = CSI;
          p0_next    = 8'd0;
          p1_next    = 8'd0;
          idx_next   = 1'b0;
        end else begin
          seq_err_next = 1'b1;
          state_next   = IDLE;
        end
      end
      CSI: if (consume) begin
        state_next = IDLE;
        if (pend_byte_reg >= 8'h30 && pend_byte_reg <= 8'h39) begin
          state_next = CSI;
          if (idx_reg) p1_next = digit_sat;
          else         p0_next = digit_sat;
        end else begin
          case (pend_byte_reg)
            8'h3B: begin
              if (!idx_reg) begin
                idx_next   = 1'b1;
                state_next = CSI;
              end else begin
                seq_err_next = 1'b1;
              end
            end
            8'h48: begin
              row_next = (p0_reg != 8'd0);
              col_next = (p1_reg > 8'd15) ? 4'd15 : p1_reg[3:0];
            end
            8'h6A: begin
              if (p0_reg == 8'd0) begin
                state_next   = CLEAR;
                clr_cnt_next = 5'd0;
              end
            end
            8'h65:   disp_next    = p0_reg;
            8'h63:   curcfg_next  = p0_reg;
            8'h68:   mode_next    = p0_reg;
            default: seq_err_next = 1'b1;
          endcase
        end
      end
      CLEAR: begin
        char_we_next   = 1'b1;
        char_addr_next = clr_cnt_reg;
        char_data_next = 8'h20;
        clr_cnt_next   = clr_cnt_reg + 5'd1;
        if (clr_cnt_reg == 5'd31) begin
          state_next = IDLE;
          row_next   = 1'b0;
          col_next   = 4'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign miso       = 1'b0;
  assign rx_valid   = rx_valid_reg;
  assign rx_byte    = rx_byte_reg;
  assign char_we    = char_we_reg;
  assign char_addr  = char_addr_reg;
  assign char_data  = char_data_reg;
  assign cursor_row = row_reg;
  assign cursor_col = col_reg;
  assign disp_cfg   = disp_reg;
  assign cursor_cfg = curcfg_reg;
  assign mode_cfg   = mode_reg;
  assign clear_busy = (state_reg == CLEAR);
  assign seq_err    = seq_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_cls_spi_rx.sv
// Bench for cls_spi_rx: drives SPI bytes at clock/4 and compares display writes,
// cursor and config registers against a scanning model of the terminal stream.
module tb_cls_spi_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ss = 1'b1, sclk = 1'b1, mosi = 1'b0;
  logic       miso, rx_valid, char_we, cursor_row, clear_busy, seq_err, overrun;
  logic [7:0] rx_byte, char_data, disp_cfg, cursor_cfg, mode_cfg;
  logic [4:0] char_addr;
  logic [3:0] cursor_col;

  cls_spi_rx dut (
    .clock(clock), .reset(reset), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .char_we(char_we), .char_addr(char_addr),
    .char_data(char_data), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .disp_cfg(disp_cfg), .cursor_cfg(cursor_cfg), .mode_cfg(mode_cfg),
    .clear_busy(clear_busy), .seq_err(seq_err), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bit8_rise = 0, rx_cyc = 0, rx_lat = -1, we_lat = -1;
  int act_seq = 0, act_ovr = 0, busy_cnt = 0;
  logic [12:0] act_w[$];
  logic [12:0] exp_w[$];
  logic [7:0]  act_rx[$];
  logic [7:0]  tx_q[$];
  logic [55:0] all_out;

  // Reference terminal state
  int m_row = 0, m_col = 0, m_disp = 0, m_cur = 0, m_mode = 0, m_err = 0;

  assign all_out = {miso, rx_valid, rx_byte, char_we, char_addr, char_data, cursor_row,
                    cursor_col, disp_cfg, cursor_cfg, mode_cfg, clear_busy, seq_err, overrun};

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (char_we) begin
      act_w.push_back({char_addr, char_data});
      we_lat = cyc - rx_cyc;
    end
    if (rx_valid) begin
      act_rx.push_back(rx_byte);
      rx_lat = cyc - bit8_rise;
      rx_cyc = cyc;
    end
    if (seq_err) act_seq++;
    if (overrun) act_ovr++;
    if (clear_busy) busy_cnt++;
  end

  task automatic clr();
    act_w.delete(); exp_w.delete(); act_rx.delete(); tx_q.delete();
    act_seq = 0; act_ovr = 0; busy_cnt = 0; m_err = 0;
  endtask

  task automatic push_str(input string s);
    for (int k = 0; k < s.len(); k++) tx_q.push_back(s[k]);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin
      sclk = 1'b0; mosi = b[k];
      repeat (2) @(negedge clock);
      sclk = 1'b1;
      if (k == 0) bit8_rise = cyc + 1;
      repeat (2) @(negedge clock);
    end
  endtask

  // Scans the byte stream as a whole: escape sequences are parsed to their final byte
  task automatic model_run();
    int i, j, idx, v, done;
    int p[2];
    logic [7:0] c;
    logic [4:0] a5;
    i = 0;
    while (i < tx_q.size()) begin
      c = tx_q[i];
      if (c == 8'h1B) begin
        if (i + 1 >= tx_q.size()) break;
        if (tx_q[i+1] != 8'h5B) begin
          m_err++; i += 2; continue;
        end
        p[0] = 0; p[1] = 0; idx = 0; done = 0; j = i + 2;
        while (j < tx_q.size() && done == 0) begin
          c = tx_q[j]; j++;
          if (c >= "0" && c <= "9") begin
            v = p[idx] * 10 + int'(c - "0");
            p[idx] = (v > 255) ? 255 : v;
          end else if (c == ";") begin
            if (idx == 0) idx = 1;
            else begin m_err++; done = 1; end
          end else begin
            done = 1;
            case (c)
              "H": begin m_row = (p[0] > 0) ? 1 : 0; m_col = (p[1] > 15) ? 15 : p[1]; end
              "j": if (p[0] == 0) begin
                for (int a = 0; a < 32; a++) begin
                  a5 = 5'(a);
                  exp_w.push_back({a5, 8'h20});
                end
                m_row = 0; m_col = 0;
              end
              "e": m_disp = p[0];
              "c": m_cur = p[0];
              "h": m_mode = p[0];
              default: m_err++;
            endcase
          end
        end
        i = j;
      end else begin
        if (c >= 8'h20 && c <= 8'h7E) begin
          a5 = 5'(m_row * 16 + m_col);
          exp_w.push_back({a5, c});
          m_col++;
          if (m_col == 16) begin m_col = 0; m_row = 1 - m_row; end
        end
        i++;
      end
    end
  endtask

  task automatic flush();
    ss = 1'b0;
    repeat (2) @(negedge clock);
    foreach (tx_q[k]) spi_byte(tx_q[k]);
    @(negedge clock);
    ss = 1'b1;
    model_run();
    repeat (80) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (all_out !== 56'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    reset = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (all_out !== 56'd0) begin
      errors++; $display("FAIL idle_after_reset: got %h want 0", all_out);
    end
    $display("test_reset: outputs %h", all_out);
  endtask

  task automatic test_config_e();
    clr();
    tx_q = '{8'h1B, 8'h5B, 8'h33, 8'h65};
    flush();
    checks++;
    if (disp_cfg !== 8'(m_disp) || disp_cfg !== 8'd3) begin
      errors++; $display("FAIL disp_cfg: got %0d want 3", disp_cfg);
    end
    checks++;
    if (act_w.size() != 0 || act_seq != 0) begin
      errors++; $display("FAIL esc_e_side: writes %0d seq_err %0d want 0 0", act_w.size(), act_seq);
    end
    checks++;
    if (rx_lat != 3) begin
      errors++; $display("FAIL sync_latency: got %0d want 3", rx_lat);
    end
    $display("test_config_e: disp_cfg=%0d rx_lat=%0d", disp_cfg, rx_lat);
  endtask

  task automatic test_goto_write();
    clr();
    tx_q = '{8'h1B, 8'h5B, "1", ";", "5", "H", 8'h41};
    flush();
    checks++;
    if (act_w.size() != 1 || exp_w.size() != 1) begin
      errors++; $display("FAIL goto_write_count: got %0d want 1", act_w.size());
    end else if (act_w[0] !== exp_w[0] || act_w[0] !== 13'h1541) begin
      errors++; $display("FAIL goto_write: got %h want %h", act_w[0], exp_w[0]);
    end
    checks++;
    if (cursor_row !== 1'b1 || cursor_col !== 4'd6) begin
      errors++; $display("FAIL goto_cursor: got %0d,%0d want 1,6", cursor_row, cursor_col);
    end
    checks++;
    if (we_lat != 2) begin
      errors++; $display("FAIL rx_to_we_latency: got %0d want 2", we_lat);
    end
    $display("test_goto_write: writes=%0d cursor=%0d,%0d we_lat=%0d", act_w.size(), cursor_row, cursor_col, we_lat);
  endtask

  task automatic test_wrap();
    clr();
    push_str("\033[1;15HB");
    flush();
    checks++;
    if (act_w.size() != 1) begin
      errors++; $display("FAIL wrap_count: got %0d want 1", act_w.size());
    end else if (act_w[0] !== 13'h1F42) begin
      errors++; $display("FAIL wrap_write: got %h want 1f42", act_w[0]);
    end
    checks++;
    if (cursor_row !== 1'b0 || cursor_col !== 4'd0 || m_row != 0 || m_col != 0) begin
      errors++; $display("FAIL wrap_cursor: got %0d,%0d want 0,0", cursor_row, cursor_col);
    end
    $display("test_wrap: cursor=%0d,%0d", cursor_row, cursor_col);
  endtask

  task automatic test_clear();
    clr();
    push_str("\033[0jC");
    flush();
    checks++;
    if (act_w.size() != 33 || exp_w.size() != 33) begin
      errors++; $display("FAIL clear_count: got %0d want 33", act_w.size());
    end else begin
      for (int k = 0; k < 33; k++) begin
        checks++;
        if (act_w[k] !== exp_w[k]) begin
          errors++; $display("FAIL clear_write[%0d]: got %h want %h", k, act_w[k], exp_w[k]);
        end
      end
    end
    checks++;
    if (busy_cnt != 32 || act_ovr != 0) begin
      errors++; $display("FAIL clear_busy_len: busy %0d overrun %0d want 32 0", busy_cnt, act_ovr);
    end
    $display("test_clear: writes=%0d busy=%0d", act_w.size(), busy_cnt);
  endtask

  task automatic test_saturate_seqerr();
    clr();
    push_str("\033[999;40H");
    flush();
    checks++;
    if (cursor_row !== 1'b1 || cursor_col !== 4'd15) begin
      errors++; $display("FAIL saturate_clamp: got %0d,%0d want 1,15", cursor_row, cursor_col);
    end
    clr();
    push_str("\033X");
    flush();
    checks++;
    if (act_seq != 1 || m_err != 1 || act_w.size() != 0) begin
      errors++; $display("FAIL esc_x: seq_err %0d writes %0d want 1 0", act_seq, act_w.size());
    end
    $display("test_saturate_seqerr: cursor=%0d,%0d seq_err=%0d", cursor_row, cursor_col, act_seq);
  endtask

  task automatic test_partial();
    logic [7:0] junk;
    clr();
    junk = 8'($urandom);
    ss = 1'b0;
    repeat (2) @(negedge clock);
    for (int k = 7; k >= 3; k--) begin
      sclk = 1'b0; mosi = junk[k];
      repeat (2) @(negedge clock);
      sclk = 1'b1;
      repeat (2) @(negedge clock);
    end
    ss = 1'b1;
    repeat (6) @(negedge clock);
    tx_q = '{8'h44};
    flush();
    checks++;
    if (act_rx.size() != 1) begin
      errors++; $display("FAIL partial_rx_count: got %0d want 1", act_rx.size());
    end else if (act_rx[0] !== 8'h44) begin
      errors++; $display("FAIL partial_rx_byte: got %h want 44", act_rx[0]);
    end
    checks++;
    if (act_w.size() != 1 || exp_w.size() != 1) begin
      errors++; $display("FAIL partial_write_count: got %0d want 1", act_w.size());
    end else if (act_w[0] !== exp_w[0]) begin
      errors++; $display("FAIL partial_write: got %h want %h", act_w[0], exp_w[0]);
    end
    $display("test_partial: rx=%0d", act_rx.size());
  endtask

  task automatic test_random(input int items);
    int kind, np, nd;
    logic [7:0] b;
    string fin;
    clr();
    fin = "Hjech";
    for (int n = 0; n < items; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        tx_q.push_back(8'($urandom_range(32, 126)));
      end else if (kind == 5) begin
        b = 8'($urandom_range(127, 255));
        if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 26));
        tx_q.push_back(b);
      end else if (kind == 6) begin
        tx_q.push_back(8'h1B);
        tx_q.push_back(8'($urandom_range(32, 90)));
      end else begin
        tx_q.push_back(8'h1B); tx_q.push_back(8'h5B);
        np = $urandom_range(0, 3);
        for (int q = 0; q < np; q++) begin
          if (q > 0) tx_q.push_back(";");
          nd = $urandom_range(0, 4);
          for (int d = 0; d < nd; d++) tx_q.push_back(8'($urandom_range(48, 57)));
        end
        if ($urandom_range(0, 7) == 0) tx_q.push_back("Z");
        else tx_q.push_back(fin[$urandom_range(0, 4)]);
      end
    end
    flush();
    checks++;
    if (act_rx.size() != tx_q.size()) begin
      errors++; $display("FAIL rand_rx_count: got %0d want %0d", act_rx.size(), tx_q.size());
    end else begin
      for (int k = 0; k < tx_q.size(); k++) begin
        checks++;
        if (act_rx[k] !== tx_q[k]) begin
          errors++; $display("FAIL rand_rx[%0d]: got %h want %h", k, act_rx[k], tx_q[k]);
        end
      end
    end
    checks++;
    if (act_w.size() != exp_w.size()) begin
      errors++; $display("FAIL rand_write_count: got %0d want %0d", act_w.size(), exp_w.size());
    end else begin
      for (int k = 0; k < exp_w.size(); k++) begin
        checks++;
        if (act_w[k] !== exp_w[k]) begin
          errors++; $display("FAIL rand_write[%0d]: got %h want %h", k, act_w[k], exp_w[k]);
        end
      end
    end
    checks++;
    if (act_seq != m_err || act_ovr != 0) begin
      errors++; $display("FAIL rand_seq_err: got %0d overrun %0d want %0d 0", act_seq, act_ovr, m_err);
    end
    checks++;
    if (disp_cfg !== 8'(m_disp) || cursor_cfg !== 8'(m_cur) || mode_cfg !== 8'(m_mode)) begin
      errors++; $display("FAIL rand_cfg: got %0d %0d %0d want %0d %0d %0d",
                         disp_cfg, cursor_cfg, mode_cfg, m_disp, m_cur, m_mode);
    end
    checks++;
    if (cursor_row !== 1'(m_row) || cursor_col !== 4'(m_col)) begin
      errors++; $display("FAIL rand_cursor: got %0d,%0d want %0d,%0d", cursor_row, cursor_col, m_row, m_col);
    end
    $display("test_random: bytes=%0d writes=%0d seq_err=%0d", tx_q.size(), act_w.size(), act_seq);
  endtask

  task automatic test_reset_mid_clear();
    int waited;
    clr();
    push_str("\033[0j");
    ss = 1'b0;
    repeat (2) @(negedge clock);
    foreach (tx_q[k]) spi_byte(tx_q[k]);
    @(negedge clock);
    ss = 1'b1;
    waited = 0;
    while (clear_busy !== 1'b1 && waited < 200) begin
      @(negedge clock); waited++;
    end
    checks++;
    if (clear_busy !== 1'b1) begin
      errors++; $display("FAIL clear_start_timeout: clear_busy %b want 1", clear_busy);
    end
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (all_out !== 56'd0) begin
      errors++; $display("FAIL reset_mid_clear: got %h want 0", all_out);
    end
    m_row = 0; m_col = 0; m_disp = 0; m_cur = 0; m_mode = 0;
    @(negedge clock);
    reset = 1'b1;
    busy_cnt = 0;
    act_w.delete();
    repeat (50) @(negedge clock);
    checks++;
    if (busy_cnt != 0 || act_w.size() != 0 || all_out !== 56'd0) begin
      errors++; $display("FAIL clear_not_resumed: busy %0d writes %0d want 0 0", busy_cnt, act_w.size());
    end
    $display("test_reset_mid_clear: busy_after=%0d", busy_cnt);
  endtask

  initial begin
    test_reset();
    test_config_e();
    test_goto_write();
    test_wrap();
    test_clear();
    test_saturate_seqerr();
    test_partial();
    test_random(40);
    test_random(40);
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
